ld_step_timer: RTL
==================

# ld_step_timer

Step-timing responder for the laser-diode current ramp. Receives `Start_C` / `Clr_C` from the LD driver state machine and returns `C_out`, a one-cycle step strobe every `Period` clocks. The driver adds or subtracts one current increment on each strobe. The block also counts issued steps for ramp-progress monitoring.

## Interface
- `CNT_W`, 16: width of the period counter and of the `Period` input.
- `DEF_PERIOD`, 1000: period used when `Period` is latched as 0.
- `STEP_W`, 10: width of the step counter.

- `CLK`  in  1  system clock, rising edge.
- `Clrn`  in  1  asynchronous active-low reset.
- `Start_C`  in  1  run enable from the driver; level-sensitive.
- `Clr_C`  in  1  synchronous clear/hold from the driver; level-sensitive; has priority over `Start_C`.
- `Period`  in  CNT_W  strobe period in clocks; latched only in ARM.
- `C_out`  out  1  step strobe; registered; high for exactly one cycle per period.
- `Busy`  out  1  high while the state is RUN.
- `Step_cnt`  out  STEP_W  strobes issued since the last clear; saturating.
- `Step_sat`  out  1  sticky; set when `Step_cnt` reaches all-ones.

## Operation
- Internal state: `state` (IDLE, ARM, RUN), `cnt` (CNT_W), `per_reg` (CNT_W).
- Latch rule: `per_reg` takes `Period`, or `DEF_PERIOD` if `Period` is 0. It is written on every cycle the state is ARM, and on the IDLE→ARM edge.
- IDLE
  - `cnt` is 0 and `C_out` is 0.
  - `Start_C`=1 → ARM, latching `per_reg`.
  - Otherwise stay in IDLE.
- ARM
  - `cnt` is held at 0 and `C_out` is 0.
  - `Start_C`=0 → IDLE.
  - `Clr_C`=1 → stay in ARM: clear `Step_cnt` and `Step_sat`, re-latch `per_reg`.
  - `Start_C`=1 and `Clr_C`=0 → RUN, with `cnt` ← 0.
- RUN, evaluated each edge in this priority order:
  - `Start_C`=0 → IDLE. `cnt` ← 0, `C_out` ← 0. `Step_cnt` is kept.
  - `Clr_C`=1 → ARM. `cnt` ← 0, `C_out` ← 0, `Step_cnt` ← 0, `Step_sat` ← 0, re-latch `per_reg`.
  - `cnt` == `per_reg`−1 → `cnt` ← 0, `C_out` ← 1, `Step_cnt` ← `Step_cnt`+1 unless already all-ones.
  - Otherwise → `cnt` ← `cnt`+1, `C_out` ← 0.
- `Step_sat` ← 1 on the edge where `Step_cnt` becomes all-ones. It stays set until a `Clr_C` clear or reset.
- `Step_cnt` never wraps.
- `Busy` = (state == RUN); it is registered through the state register.
- Changes to `Period` during RUN are ignored until the block re-enters ARM.
- All comparisons are unsigned, CNT_W wide. `per_reg`=1 gives a strobe on every RUN cycle.
- Asynchronous reset (`Clrn`=0), at any time including mid-run:
  - state IDLE, `cnt` 0, `per_reg` `DEF_PERIOD`;
  - `C_out` 0, `Busy` 0, `Step_cnt` 0, `Step_sat` 0.

## Timing
- Edge E0: the ARM→RUN edge. The first `C_out` is high for the cycle following edge E0+P, where P = `per_reg`. Later strobes follow every P edges.
- From IDLE with `Start_C`=1 and `Clr_C`=0 held: IDLE→ARM at edge 1, ARM→RUN at edge 2, first strobe after edge 2+P.
- Strobe cycle versus step count: `Step_cnt` updates on the same edge that raises `C_out`, so both are visible in the same cycle.
- `Clr_C`=1 in RUN takes effect on the next edge: no strobe in the following cycle, even if `cnt` was at P−1.
- If `Clr_C` and `Start_C` both fall on the same edge, the block goes to IDLE.
- The driver may hold `Start_C`=1 indefinitely and pulse `Clr_C`. Each `Clr_C` pulse costs one ARM cycle before counting resumes.
- Inputs are assumed synchronous to `CLK`; there is no internal synchronizer.

## Test plan
- Reset, then `Start_C`=1, `Clr_C`=0, `Period`=5:
  - `Busy` rises after edge 2;
  - `C_out` pulses after edges 7, 12 and 17, one cycle wide each;
  - `Step_cnt` reads 1, 2, 3 in the strobe cycles.
- `Period`=0 → first strobe after edge 2+1000. `Period`=1 → `C_out` high on every RUN cycle and `Step_cnt` increments every cycle.
- In RUN with `Period`=4, assert `Clr_C` for 3 cycles while `cnt`=3:
  - no strobe;
  - `Step_cnt`=0, `Step_sat`=0;
  - `Period` changed to 6 during the hold is applied; first strobe 6 edges after RUN re-entry.
- With `STEP_W`=4 and `Period`=1, run 20 cycles:
  - `Step_cnt` stops at 15 and `Step_sat` goes to 1 on the 15th strobe;
  - `C_out` keeps pulsing;
  - a `Clr_C` pulse clears both.
- Mid-run `Start_C`=0 → IDLE next edge: `Busy`=0, `C_out`=0, `Step_cnt` retained. Changing `Period` in RUN from 5 to 3 has no effect on strobe spacing.
- Assert `Clrn`=0 asynchronously between edges in RUN: all outputs go to 0 immediately. After release with `Start_C`=1, the first strobe follows after edge 2+`Period`.

Source files
------------

// File: rtl/ld_step_timer.sv
// -----------------------------------------------------------------------------
// ld_step_timer
//
// Step-timing responder for the laser-diode current ramp. The LD driver state
// machine arms the block with Start_C and holds/clears it with Clr_C. While
// running, a one-cycle step strobe (C_out) is issued every per_reg clocks, and
// issued strobes are counted in a saturating step counter.
//
// Parameters
//   CNT_W      width of the period counter and of the Period input
//   DEF_PERIOD period used when Period is latched as 0
//   STEP_W     width of the step counter
//
// Ports
//   CLK       in   system clock, rising edge
//   Clrn      in   asynchronous active-low reset
//   Start_C   in   run enable (level)
//   Clr_C     in   synchronous clear/hold (level), wins over Start_C=1
//   Period    in   strobe period in clocks, latched only around ARM
//   C_out     out  registered step strobe, one cycle per period
//   Busy      out  high while in RUN
//   Step_cnt  out  strobes since last clear, saturating
//   Step_sat  out  sticky flag, set when Step_cnt reaches all-ones
// -----------------------------------------------------------------------------
module ld_step_timer #(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 1000,
    parameter int STEP_W     = 10
) (
    input  logic              CLK,
    input  logic              Clrn,
    input  logic              Start_C,
    input  logic              Clr_C,
    input  logic [CNT_W-1:0]  Period,
    output logic              C_out,
    output logic              Busy,
    output logic [STEP_W-1:0] Step_cnt,
    output logic              Step_sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  DEF_PER  = CNT_W'(DEF_PERIOD);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    per_reg_q, per_reg_d;
    logic                c_out_q, c_out_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic                step_sat_q, step_sat_d;

    logic [CNT_W-1:0]    period_eff;
    logic                at_wrap;
    logic                run_go;
    logic                strobe;
    logic                clr_hit;
    logic                latch_per;

    // A zero Period would never produce a strobe, so it selects the default.
    assign period_eff = (Period == '0) ? DEF_PER : Period;

    // per_reg is never 0, so per_reg-1 cannot underflow.
    assign at_wrap = (cnt_q == (per_reg_q - CNT_W'(1)));

    // Counting only continues in RUN with Start_C held and no clear request.
    assign run_go  = (state_q == RUN) && Start_C && !Clr_C;
    assign strobe  = run_go && at_wrap;

    // A clear only acts when Start_C is still high; Start_C=0 sends the block
    // to IDLE with the step count kept.
    assign clr_hit = Start_C && Clr_C && ((state_q == ARM) || (state_q == RUN));

    // per_reg follows Period on every ARM cycle and on each edge into ARM.
    assign latch_per = (state_q == ARM)
                    || ((state_q == IDLE) && Start_C)
                    || ((state_q == RUN) && Start_C && Clr_C);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Start_C) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!Start_C) begin
                    state_d = IDLE;
                end else if (!Clr_C) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!Start_C) begin
                    state_d = IDLE;
                end else if (Clr_C) begin
                    state_d = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath next values
    always_comb begin
        cnt_d      = '0;
        c_out_d    = strobe;
        per_reg_d  = per_reg_q;
        step_cnt_d = step_cnt_q;
        step_sat_d = step_sat_q;

        if (run_go && !at_wrap) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (latch_per) begin
            per_reg_d = period_eff;
        end

        if (clr_hit) begin
            step_cnt_d = '0;
            step_sat_d = 1'b0;
        end else if (strobe && (step_cnt_q != STEP_MAX)) begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
            if (step_cnt_q == (STEP_MAX - STEP_W'(1))) begin
                step_sat_d = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            cnt_q      <= '0;
            per_reg_q  <= DEF_PER;
            c_out_q    <= 1'b0;
            step_cnt_q <= '0;
            step_sat_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_reg_q  <= per_reg_d;
            c_out_q    <= c_out_d;
            step_cnt_q <= step_cnt_d;
            step_sat_q <= step_sat_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        C_out    = c_out_q;
        Busy     = (state_q == RUN);
        Step_cnt = step_cnt_q;
        Step_sat = step_sat_q;
    end

endmodule
